// File: rtl/harvard_mem_responder.sv
// Memory-side responder for a Harvard MIPS core: loadable boot ROM on the fetch bus and a
// data RAM on the data bus, with a sticky access-fault flag and a saturating write counter.
module harvard_mem_responder #(
  parameter logic [31:0] ROM_BASE = 32'hBFC00000,
  parameter int unsigned ROM_AW   = 8,
  parameter logic [31:0] RAM_BASE = 32'h00000000,
  parameter int unsigned RAM_AW   = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        init_mem_i,
  input  logic [31:0] init_mem_addr_i,
  input  logic [31:0] init_instr_i,
  output logic        instr_active_o,
  input  logic [31:0] instr_address_i,
  output logic [31:0] instr_readdata_o,
  input  logic [31:0] data_address_i,
  input  logic        data_write_i,
  input  logic        data_read_i,
  input  logic [31:0] data_writedata_i,
  output logic [31:0] data_readdata_o,
  output logic        fault_o,
  output logic [15:0] write_count_o
);

  localparam int unsigned RomDepth = 2 ** ROM_AW;
  localparam int unsigned RamDepth = 2 ** RAM_AW;

  typedef enum logic [1:0] {StEmpty, StLoad, StReady} state_e;

  state_e      state_q;
  logic        instr_active_q;
  logic        fault_q, fault_d;
  logic [15:0] wcount_q, wcount_d;

  logic [31:0] rom_q [RomDepth];
  logic [31:0] ram_q [RamDepth];

  // Window offsets; a hit means every offset bit above the word index is zero.
  logic [31:0] fetch_off, ld_off, d_rom_off, d_ram_off;
  logic        fetch_hit, ld_hit, d_rom_hit, d_ram_hit;
  logic [ROM_AW-1:0] fetch_idx, ld_idx, d_rom_idx;
  logic [RAM_AW-1:0] d_ram_idx;

  assign fetch_off = instr_address_i - ROM_BASE;
  assign ld_off    = init_mem_addr_i - ROM_BASE;
  assign d_rom_off = data_address_i - ROM_BASE;
  assign d_ram_off = data_address_i - RAM_BASE;

  assign fetch_hit = (fetch_off >> (ROM_AW + 2)) == 32'h0;
  assign ld_hit    = (ld_off >> (ROM_AW + 2)) == 32'h0;
  assign d_rom_hit = (d_rom_off >> (ROM_AW + 2)) == 32'h0;
  assign d_ram_hit = (d_ram_off >> (RAM_AW + 2)) == 32'h0;

  assign fetch_idx = fetch_off[ROM_AW+1:2];
  assign ld_idx    = ld_off[ROM_AW+1:2];
  assign d_rom_idx = d_rom_off[ROM_AW+1:2];
  assign d_ram_idx = d_ram_off[RAM_AW+1:2];

  logic d_aligned, ld_aligned, rom_we, ram_we, fault_set;

  assign d_aligned  = data_address_i[1:0] == 2'b00;
  assign ld_aligned = init_mem_addr_i[1:0] == 2'b00;
  assign rom_we     = !reset_i && init_mem_i && ld_hit && ld_aligned;
  assign ram_we     = !reset_i && data_write_i && d_ram_hit && d_aligned;

  assign fault_set = ((data_read_i || data_write_i) && !d_aligned)
                   || (data_write_i && !d_ram_hit)
                   || (data_read_i && data_write_i)
                   || (init_mem_i && (!ld_hit || !ld_aligned))
                   || ((state_q == StReady) && !fetch_hit);

  always_comb begin
    fault_d  = fault_q | fault_set;
    wcount_d = wcount_q;
    if (ram_we && (wcount_q != 16'hFFFF)) begin
      wcount_d = wcount_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StEmpty;
      instr_active_q <= 1'b0;
      fault_q        <= 1'b0;
      wcount_q       <= 16'h0;
    end else begin
      unique case (state_q)
        StEmpty: if (init_mem_i) state_q <= StLoad;
        StLoad: begin
          if (!init_mem_i) begin
            state_q        <= StReady;
            instr_active_q <= 1'b1;
          end
        end
        StReady: begin
          if (init_mem_i) begin
            state_q        <= StLoad;
            instr_active_q <= 1'b0;
          end
        end
        default: begin
          state_q        <= StEmpty;
          instr_active_q <= 1'b0;
        end
      endcase
      fault_q  <= fault_d;
      wcount_q <= wcount_d;
    end
  end

  // Arrays are deliberately not reset so a CPU reset can rerun the loaded image.
  always_ff @(posedge clk_i) begin
    if (rom_we) rom_q[ld_idx] <= init_instr_i;
    if (ram_we) ram_q[d_ram_idx] <= data_writedata_i;
  end

  always_comb begin
    instr_readdata_o = 32'h0;
    if ((state_q == StReady) && fetch_hit && (instr_address_i[1:0] == 2'b00)) begin
      instr_readdata_o = rom_q[fetch_idx];
    end
    data_readdata_o = 32'h0;
    if (data_read_i && d_aligned) begin
      if (d_ram_hit) begin
        data_readdata_o = ram_q[d_ram_idx];
      end else if (d_rom_hit) begin
        data_readdata_o = rom_q[d_rom_idx];
      end
    end
  end

  assign instr_active_o = instr_active_q;
  assign fault_o        = fault_q;
  assign write_count_o  = wcount_q;

endmodule

// File: tb/tb_harvard_mem_responder.sv
// Scoreboard bench for harvard_mem_responder: the driver queues expected output values for each
// cycle, and a negedge monitor pops and compares them against the DUT outputs.
module tb_harvard_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_mem;
  logic [31:0] init_mem_addr, init_instr;
  logic        instr_active;
  logic [31:0] instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic        data_write, data_read, fault;
  logic [15:0] write_count;

  harvard_mem_responder dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .init_mem_i       (init_mem),
    .init_mem_addr_i  (init_mem_addr),
    .init_instr_i     (init_instr),
    .instr_active_o   (instr_active),
    .instr_address_i  (instr_address),
    .instr_readdata_o (instr_readdata),
    .data_address_i   (data_address),
    .data_write_i     (data_write),
    .data_read_i      (data_read),
    .data_writedata_i (data_writedata),
    .data_readdata_o  (data_readdata),
    .fault_o          (fault),
    .write_count_o    (write_count)
  );

  always #5 clk = ~clk;

  localparam int SelInstr = 0, SelData = 1, SelFault = 2, SelCount = 3, SelActive = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t        sb_q[$];
  chk_t        cur;
  logic [31:0] act;
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam logic [31:0] W0 = 32'h24080001, W1 = 32'h0EFF0002, W2 = 32'h3C09DEAD,
                          W3 = 32'hAC090010;
  localparam logic [31:0] N0 = 32'h11110000, N1 = 32'h0EFF0002, N2 = 32'h22220008,
                          N3 = 32'h33330000;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sb_q.push_back(c);
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] word);
    cyc();
    init_mem      = 1'b1;
    init_mem_addr = addr;
    init_instr    = word;
  endtask

  task automatic dwrite(input logic [31:0] addr, input logic [31:0] wd, input logic rd);
    cyc();
    data_address   = addr;
    data_writedata = wd;
    data_write     = 1'b1;
    data_read      = rd;
  endtask

  task automatic dread(input logic [31:0] addr);
    cyc();
    data_address = addr;
    data_write   = 1'b0;
    data_read    = 1'b1;
  endtask

  // Monitor: the DUT responds every cycle, so each queued expectation is checked mid-cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      case (cur.sel)
        SelInstr: act = instr_readdata;
        SelData:  act = data_readdata;
        SelFault: act = {31'h0, fault};
        SelCount: act = {16'h0, write_count};
        default:  act = {31'h0, instr_active};
      endcase
      n_cmp++;
      if (act !== cur.exp) begin
        n_bad++;
        $display("FAIL %s: got %h, want %h", cur.name, act, cur.exp);
      end
    end
  end

  initial begin
    reset = 1'b1;  init_mem = 1'b0;  init_mem_addr = '0;  init_instr = '0;
    instr_address = 32'hBFC00008;  data_address = '0;  data_write = 1'b0;
    data_read = 1'b0;  data_writedata = '0;
    cyc();
    cyc();
    reset = 1'b0;
    expect_val("rst_active", SelActive, 32'h0);
    expect_val("rst_fault", SelFault, 32'h0);
    expect_val("rst_count", SelCount, 32'h0);
    expect_val("fetch_before_load", SelInstr, 32'h0);
    expect_val("rst_dread_idle", SelData, 32'h0);

    load(32'hBFC00000, W0);
    expect_val("empty_active", SelActive, 32'h0);
    load(32'hBFC00004, W1);
    load(32'hBFC00008, W2);
    load(32'hBFC0000C, W3);
    cyc();
    init_mem = 1'b0;
    expect_val("load_drop_active", SelActive, 32'h0);
    cyc();
    expect_val("ready_active", SelActive, 32'h1);
    expect_val("fetch_word2", SelInstr, W2);
    cyc();
    instr_address = 32'hBFC0000A;
    expect_val("fetch_unaligned", SelInstr, 32'h0);

    dwrite(32'h00000010, 32'hDEADBEEF, 1'b0);
    instr_address = 32'hBFC00000;
    expect_val("fetch_word0", SelInstr, W0);
    expect_val("wr_no_read", SelData, 32'h0);
    expect_val("wr_count_pre", SelCount, 32'h0);
    dread(32'h00000010);
    expect_val("rd_after_wr", SelData, 32'hDEADBEEF);
    expect_val("wr_count_1", SelCount, 32'h1);
    expect_val("wr_no_fault", SelFault, 32'h0);
    dwrite(32'h00000004, 32'h5, 1'b0);
    dread(32'h00000004);
    expect_val("rd_addr4", SelData, 32'h5);
    expect_val("wr_count_2", SelCount, 32'h2);
    dread(32'h00001000);
    expect_val("rd_unmapped", SelData, 32'h0);
    expect_val("unmapped_rd_no_fault", SelFault, 32'h0);
    dread(32'hBFC00004);
    expect_val("rd_rom_const", SelData, W1);

    dwrite(32'hBFC00000, 32'h12345678, 1'b0);
    expect_val("rom_wr_fault_pre", SelFault, 32'h0);
    dread(32'hBFC00000);
    expect_val("rom_wr_fault", SelFault, 32'h1);
    expect_val("rom_unchanged_data", SelData, W0);
    expect_val("rom_unchanged_fetch", SelInstr, W0);
    expect_val("rom_wr_no_count", SelCount, 32'h2);
    dread(32'h00000012);
    expect_val("rd_unaligned", SelData, 32'h0);

    dwrite(32'h00000004, 32'h9, 1'b1);
    expect_val("rw_same_cycle_old", SelData, 32'h5);
    dread(32'h00000004);
    expect_val("rw_next_new", SelData, 32'h9);
    expect_val("rw_count_3", SelCount, 32'h3);
    expect_val("fault_sticky", SelFault, 32'h1);

    // Full responder reset, then reset again partway through a load.
    cyc();
    data_read = 1'b0;
    reset     = 1'b1;
    cyc();
    reset = 1'b0;
    expect_val("rst2_active", SelActive, 32'h0);
    expect_val("rst2_fault", SelFault, 32'h0);
    expect_val("rst2_count", SelCount, 32'h0);
    load(32'hBFC00000, N0);
    load(32'hBFC00004, N1);
    load(32'hBFC00008, N2);
    reset = 1'b1;
    expect_val("midload_active", SelActive, 32'h0);
    cyc();
    reset        = 1'b0;
    init_mem     = 1'b0;
    data_read    = 1'b1;
    data_address = 32'hBFC00008;
    expect_val("midload_rst_active", SelActive, 32'h0);
    expect_val("midload_empty_fetch", SelInstr, 32'h0);
    expect_val("reset_edge_wr_suppressed", SelData, W2);
    dread(32'hBFC00004);
    expect_val("partial_load_kept", SelData, N1);
    dread(32'h00000010);
    expect_val("ram_kept_over_reset", SelData, 32'hDEADBEEF);
    expect_val("empty_stays_inactive", SelActive, 32'h0);

    cyc();
    data_read = 1'b0;
    load(32'hBFC00000, N0);
    load(32'hBFC00004, N1);
    load(32'hBFC00008, N2);
    load(32'hBFC0000C, N3);
    cyc();
    init_mem = 1'b0;
    expect_val("reload_drop_active", SelActive, 32'h0);
    cyc();
    instr_address = 32'hBFC00004;
    expect_val("reload_active", SelActive, 32'h1);
    expect_val("fetch_jal", SelInstr, N1);
    cyc();
    instr_address = 32'hBFC00008;
    expect_val("fetch_jal_target", SelInstr, N2);
    expect_val("reload_no_fault", SelFault, 32'h0);

    load(32'h00000000, 32'hFFFFFFFF);
    expect_val("bad_load_fault_pre", SelFault, 32'h0);
    cyc();
    init_mem = 1'b0;
    expect_val("bad_load_fault", SelFault, 32'h1);
    expect_val("bad_load_in_load", SelActive, 32'h0);
    expect_val("load_state_fetch_nop", SelInstr, 32'h0);
    cyc();
    expect_val("bad_load_discarded", SelInstr, N2);
    expect_val("bad_load_ready", SelActive, 32'h1);

    cyc();
    cyc();
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
